// File: rtl/sramlike_bus_arbiter_pkg.sv
// Shared types for the inst/data sram-like bus arbiter: FSM encoding, grant
// codes, master command payload and the streak update rule.
package sramlike_bus_arbiter_pkg;

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_cmd_t;

  // Data wins over a waiting inst bump the streak (saturating); anything else clears it.
  function automatic logic [STREAK_W-1:0] streak_next(
    input logic [STREAK_W-1:0] cur,
    input logic [STREAK_W-1:0] max_v,
    input logic                data_win,
    input logic                inst_pending
  );
    if (data_win && inst_pending) begin
      return (cur >= max_v) ? max_v : cur + STREAK_W'(1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/sramlike_bus_arbiter_arb_pick.sv
// Winner selection: data has priority unless inst has waited out a full
// streak of data grants.
module sramlike_bus_arbiter_arb_pick
  import sramlike_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                inst_req,
  input  logic                data_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                win_c
);

  logic starved_c;

  always_comb begin
    starved_c = inst_req && (streak == STREAK_W'(MAX_STREAK));
    win_c     = (data_req && !starved_c) ? GNT_DATA : GNT_INST;
  end

endmodule

// File: rtl/sramlike_bus_arbiter.sv
// Shares one sram-like master port between the CPU inst and data requesters,
// one outstanding transaction, with back-to-back re-arbitration from DATA.
module sramlike_bus_arbiter
  import sramlike_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              grant,
  output logic              busy
);

  arb_state_e          state_q, state_d;
  logic                grant_q, grant_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                m_req_q, m_req_d;
  logic                busy_q, busy_d;
  sram_cmd_t           cmd_q, cmd_d;
  sram_cmd_t           inst_cmd_c, data_cmd_c;
  logic                win_c, arbitrate_c, addr_hit_c, data_hit_c;

  assign inst_cmd_c = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
  assign data_cmd_c = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

  sramlike_bus_arbiter_arb_pick #(
    .MAX_STREAK(MAX_STREAK)
  ) u_arb_pick (
    .inst_req(inst_req),
    .data_req(data_req),
    .streak  (streak_q),
    .win_c   (win_c)
  );

  // Slave handshakes only count in the phase that expects them.
  assign addr_hit_c = (state_q == ARB_ADDR) && m_addr_ok;
  assign data_hit_c = (state_q == ARB_DATA) && m_data_ok;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    streak_d    = streak_q;
    cmd_d       = cmd_q;
    arbitrate_c = 1'b0;
    case (state_q)
      ARB_IDLE: arbitrate_c = inst_req || data_req;
      ARB_ADDR: if (addr_hit_c) state_d = ARB_DATA;
      ARB_DATA: begin
        if (data_hit_c) begin
          if (inst_req || data_req) arbitrate_c = 1'b1;
          else                      state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Requesters hold fields until addr_ok, so capturing at grant is exact.
    if (arbitrate_c) begin
      state_d  = ARB_ADDR;
      grant_d  = win_c;
      cmd_d    = (win_c == GNT_DATA) ? data_cmd_c : inst_cmd_c;
      streak_d = streak_next(streak_q, STREAK_W'(MAX_STREAK), win_c == GNT_DATA, inst_req);
    end
    m_req_d = (state_d == ARB_ADDR);
    busy_d  = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      grant_q  <= GNT_INST;
      streak_q <= '0;
      m_req_q  <= 1'b0;
      busy_q   <= 1'b0;
      cmd_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      streak_q <= streak_d;
      m_req_q  <= m_req_d;
      busy_q   <= busy_d;
      cmd_q    <= cmd_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_wr    = cmd_q.wr;
  assign m_size  = cmd_q.size;
  assign m_addr  = cmd_q.addr;
  assign m_wdata = cmd_q.wdata;
  assign grant   = grant_q;
  assign busy    = busy_q;

  assign inst_addr_ok = addr_hit_c && (grant_q == GNT_INST);
  assign data_addr_ok = addr_hit_c && (grant_q == GNT_DATA);
  assign inst_data_ok = data_hit_c && (grant_q == GNT_INST);
  assign data_data_ok = data_hit_c && (grant_q == GNT_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

endmodule

// File: tb/tb_sramlike_bus_arbiter.sv
// Scoreboard bench for sramlike_bus_arbiter: behavioural requesters and slave,
// expected transactions queued in grant order and checked by a monitor.
module tb_sramlike_bus_arbiter;

  localparam logic P_INST = 1'b0;
  localparam logic P_DATA = 1'b1;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        port;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        nxt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, m_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok, grant, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;

  cmd_t inst_src_q[$];
  cmd_t data_src_q[$];
  exp_t exp_addr_q[$];
  exp_t exp_data_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int addr_stall = 0;
  int data_lat   = 1;
  logic stray = 1'b0;

  always #5 clk = ~clk;

  sramlike_bus_arbiter #(.MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .grant(grant), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen with no expectation (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] slave_mem(input logic [31:0] a);
    case (a)
      32'hBFC00000: return 32'h3C1D0000;
      32'h80000000: return 32'h11112222;
      32'h80000004: return 32'h33334444;
      default:      return {16'hDEAD, a[15:0]};
    endcase
  endfunction

  task automatic push_src(input logic port, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    cmd_t c;
    c = '{wr: wr, size: size, addr: addr, wdata: wdata};
    if (port == P_DATA) data_src_q.push_back(c);
    else                inst_src_q.push_back(c);
  endtask

  task automatic push_exp(input logic port, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic nxt);
    exp_t e;
    e = '{port: port, wr: wr, size: size, addr: addr, wdata: wdata, rdata: rdata, nxt: nxt};
    exp_addr_q.push_back(e);
    exp_data_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || inst_req || data_req || inst_src_q.size() != 0 ||
                data_src_q.size() != 0 || exp_data_q.size() != 0) && n < budget);
    chk(name, 32'(n < budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Requesters: hold a request until its addr_ok, then present the next one.
  initial begin
    logic i_acc, d_acc;
    cmd_t c;
    forever begin
      @(negedge clk);
      i_acc = inst_addr_ok;
      d_acc = data_addr_ok;
      @(posedge clk);
      #1;
      if (!rst) begin
        inst_req = 1'b0;
        data_req = 1'b0;
      end else begin
        if (i_acc || !inst_req) begin
          if (inst_src_q.size() != 0) begin
            c = inst_src_q.pop_front();
            inst_req = 1'b1; inst_wr = c.wr; inst_size = c.size;
            inst_addr = c.addr; inst_wdata = c.wdata;
          end else inst_req = 1'b0;
        end
        if (d_acc || !data_req) begin
          if (data_src_q.size() != 0) begin
            c = data_src_q.pop_front();
            data_req = 1'b1; data_wr = c.wr; data_size = c.size;
            data_addr = c.addr; data_wdata = c.wdata;
          end else data_req = 1'b0;
        end
      end
    end
  end

  // Slave: addr_ok after addr_stall cycles of m_req, data_ok data_lat cycles later.
  initial begin
    int stall_cnt, wait_cnt;
    logic s_phase;
    logic [31:0] lat_addr;
    stall_cnt = 0; wait_cnt = 0; s_phase = 1'b0; lat_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      m_addr_ok = 1'b0;
      m_data_ok = 1'b0;
      if (!rst) begin
        s_phase = 1'b0;
        stall_cnt = 0;
      end else if (s_phase) begin
        if (wait_cnt > 1) wait_cnt--;
        else begin
          m_data_ok = 1'b1;
          m_rdata = slave_mem(lat_addr);
          s_phase = 1'b0;
        end
      end else if (m_req) begin
        if (stall_cnt < addr_stall) stall_cnt++;
        else begin
          m_addr_ok = 1'b1;
          lat_addr = m_addr;
          s_phase = 1'b1;
          wait_cnt = data_lat;
          stall_cnt = 0;
        end
      end
      if (stray) m_data_ok = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every addr_ok / data_ok the DUT presents.
  initial begin
    logic chk_nxt, nxt_exp;
    exp_t e;
    chk_nxt = 1'b0; nxt_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_nxt) begin
        chk("next_cycle_m_req", 32'(m_req), 32'(nxt_exp));
        chk_nxt = 1'b0;
      end
      if (inst_addr_ok || data_addr_ok) begin
        if (exp_addr_q.size() == 0) flag("unexpected_addr_ok");
        else begin
          e = exp_addr_q.pop_front();
          chk("addr_ok_both", 32'(inst_addr_ok & data_addr_ok), 32'd0);
          chk("addr_ok_port", 32'(data_addr_ok), 32'(e.port));
          chk("grant", 32'(grant), 32'(e.port));
          chk("m_req", 32'(m_req), 32'd1);
          chk("m_addr", m_addr, e.addr);
          chk("m_wr", 32'(m_wr), 32'(e.wr));
          chk("m_size", 32'(m_size), 32'(e.size));
          if (e.wr) chk("m_wdata", m_wdata, e.wdata);
        end
      end
      if (inst_data_ok || data_data_ok) begin
        if (exp_data_q.size() == 0) flag("unexpected_data_ok");
        else begin
          e = exp_data_q.pop_front();
          chk("data_ok_both", 32'(inst_data_ok & data_data_ok), 32'd0);
          chk("data_ok_port", 32'(data_data_ok), 32'(e.port));
          chk("rdata", e.port ? data_rdata : inst_rdata, e.rdata);
          chk_nxt = 1'b1;
          nxt_exp = e.nxt;
        end
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_oks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Inst-only read, data_ok two cycles after addr_ok.
    data_lat = 2;
    push_src(P_INST, 1'b0, 2'd2, 32'hBFC00000, 32'h0);
    push_exp(P_INST, 1'b0, 2'd2, 32'hBFC00000, 32'h0, 32'h3C1D0000, 1'b0);
    wait_idle("inst_only_done", 50);

    // Simultaneous: data write first, inst read straight after from DATA.
    data_lat = 1;
    push_src(P_DATA, 1'b1, 2'd2, 32'h80001000, 32'h12345678);
    push_src(P_INST, 1'b0, 2'd2, 32'hBFC00004, 32'h0);
    push_exp(P_DATA, 1'b1, 2'd2, 32'h80001000, 32'h12345678, 32'hDEAD1000, 1'b1);
    push_exp(P_INST, 1'b0, 2'd2, 32'hBFC00004, 32'h0, 32'hDEAD0004, 1'b0);
    wait_idle("simul_done", 50);

    // Back-to-back data loads.
    push_src(P_DATA, 1'b0, 2'd2, 32'h80000000, 32'h0);
    push_src(P_DATA, 1'b0, 2'd2, 32'h80000004, 32'h0);
    push_exp(P_DATA, 1'b0, 2'd2, 32'h80000000, 32'h0, 32'h11112222, 1'b1);
    push_exp(P_DATA, 1'b0, 2'd2, 32'h80000004, 32'h0, 32'h33334444, 1'b0);
    wait_idle("b2b_done", 50);

    // Starvation: expected grants D,D,D,D,I,D,D,D,D,I.
    for (int k = 0; k < 8; k++)
      push_src(P_DATA, 1'b1, 2'd2, 32'h80002000 + 32'(4 * k), 32'hA0000000 + 32'(k));
    for (int j = 0; j < 2; j++)
      push_src(P_INST, 1'b0, 2'd2, 32'hBFC00010 + 32'(4 * j), 32'h0);
    begin
      int d, i;
      d = 0; i = 0;
      for (int g = 0; g < 10; g++) begin
        if (g % 5 == 4) begin
          push_exp(P_INST, 1'b0, 2'd2, 32'hBFC00010 + 32'(4 * i), 32'h0,
                   32'hDEAD0010 + 32'(4 * i), (g == 9) ? 1'b0 : 1'b1);
          i++;
        end else begin
          push_exp(P_DATA, 1'b1, 2'd2, 32'h80002000 + 32'(4 * d), 32'hA0000000 + 32'(d),
                   32'hDEAD2000 + 32'(4 * d), 1'b1);
          d++;
        end
      end
    end
    wait_idle("starve_done", 200);

    // Slave stall: addr_ok withheld for 10 ADDR cycles.
    addr_stall = 10;
    push_src(P_DATA, 1'b0, 2'd2, 32'h80003000, 32'h0);
    push_exp(P_DATA, 1'b0, 2'd2, 32'h80003000, 32'h0, 32'hDEAD3000, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!m_req && n < 20);
    chk("stall_reach_addr", 32'(m_req), 32'd1);
    for (int c = 0; c < 10; c++) begin
      chk("stall_m_req", 32'(m_req), 32'd1);
      chk("stall_m_addr", m_addr, 32'h80003000);
      chk("stall_no_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      chk("stall_grant", 32'(grant), 32'(P_DATA));
      @(negedge clk);
    end
    wait_idle("stall_done", 50);
    addr_stall = 0;

    // Reset during DATA drops the transaction.
    data_lat = 3;
    push_src(P_DATA, 1'b0, 2'd2, 32'h80004000, 32'h0);
    push_exp(P_DATA, 1'b0, 2'd2, 32'h80004000, 32'h0, 32'hDEAD4000, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(busy && !m_req) && n < 20);
    chk("reach_data_phase", 32'(busy && !m_req), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    exp_data_q.delete();
    chk("midrst_m_req", 32'(m_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    rst = 1'b1;
    data_lat = 1;
    repeat (3) @(negedge clk);

    // Stray m_data_ok while idle must be ignored.
    stray = 1'b1;
    @(negedge clk);
    chk("stray_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);
    stray = 1'b0;
    @(negedge clk);
    chk("stray_after_busy", 32'(busy), 32'd0);
    chk("stray_after_m_req", 32'(m_req), 32'd0);

    chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("data_queue_drained", 32'(exp_data_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
